// File: rtl/key_event_tracker.sv
// Commits debounced key changes one at a time, lowest index first, into key_num
// and queues a matching press/release event in a first-word fall-through FIFO.
module key_event_tracker #(
    parameter int unsigned NKEYS = 17,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NKEYS-1:0]         keys_in,
    output logic [NKEYS-1:0]         key_num,
    output logic                     note_ready,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [4:0]               ev_key,
    output logic                     ev_press,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [NKEYS-1:0] keys_q;
    logic [NKEYS-1:0] pending;
    logic [NKEYS-1:0] lowest;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [5:0]       mem [DEPTH];
    logic [5:0]       head;
    logic [4:0]       sel_idx;
    logic             sel_press;
    logic             full;
    logic             commit;
    logic             pop;

    assign pending   = keys_q ^ key_num;
    // Two's-complement trick isolates the lowest set bit of pending.
    assign lowest    = pending & (~pending + NKEYS'(1));
    assign sel_press = |(keys_q & lowest);
    assign full      = (ev_count == FULL_COUNT);
    assign commit    = (|pending) && !full;
    assign ev_valid  = (ev_count != '0);
    assign pop       = ev_valid && ev_ready;

    always_comb begin
        sel_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx = 5'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            keys_q     <= '0;
            key_num    <= '0;
            note_ready <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ev_count   <= '0;
        end else begin
            keys_q     <= keys_in;
            note_ready <= commit;
            if ((|pending) && full) overflow <= 1'b1;
            if (commit) begin
                key_num <= key_num ^ lowest;
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({commit, pop})
                2'b10:   ev_count <= ev_count + (AW + 1)'(1);
                2'b01:   ev_count <= ev_count - (AW + 1)'(1);
                default: ev_count <= ev_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count gate every read.
    always_ff @(posedge clock) begin
        if (commit && !reset) mem[wr_ptr] <= {sel_idx, sel_press};
    end

    assign head     = mem[rd_ptr];
    assign ev_key   = ev_valid ? head[5:1] : 5'd0;
    assign ev_press = ev_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_key_event_tracker.sv
// Bench for key_event_tracker: directed scenarios plus random stimulus, all checked
// each cycle against a queue-based reference model of the commit/FIFO rules.
module tb_key_event_tracker;

    localparam int NK = 17;
    localparam int D  = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_in;
    logic [NK-1:0] key_num;
    logic          note_ready;
    logic          ev_valid;
    logic          ev_ready;
    logic [4:0]    ev_key;
    logic          ev_press;
    logic [3:0]    ev_count;
    logic          overflow;

    key_event_tracker #(.NKEYS(NK), .DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .keys_in    (keys_in),
        .key_num    (key_num),
        .note_ready (note_ready),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_key     (ev_key),
        .ev_press   (ev_press),
        .ev_count   (ev_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: sampled keys, committed vector, event queue (key*2+press).
    logic [NK-1:0] m_keys;
    logic [NK-1:0] m_num;
    logic          m_note;
    logic          m_ovf;
    int            m_q[$];
    int            drained[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_model();
        int hk;
        int hp;
        hk = (m_q.size() != 0) ? m_q[0] / 2 : 0;
        hp = (m_q.size() != 0) ? m_q[0] % 2 : 0;
        check("key_num", 32'(key_num), 32'(m_num));
        check("note_ready", 32'(note_ready), 32'(m_note));
        check("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
        check("ev_key", 32'(ev_key), 32'(hk));
        check("ev_press", 32'(ev_press), 32'(hp));
        check("ev_count", 32'(ev_count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic model_step(input logic [NK-1:0] k, input logic rdy, input logic rst);
        logic [NK-1:0] pend;
        bit            found;
        bit            full;
        bit            do_pop;
        if (rst) begin
            m_keys = '0;
            m_num  = '0;
            m_note = 1'b0;
            m_ovf  = 1'b0;
            m_q.delete();
            return;
        end
        pend   = m_keys ^ m_num;
        full   = (m_q.size() == D);
        do_pop = (m_q.size() != 0) && rdy;
        if (pend != 0 && full) m_ovf = 1'b1;
        if (do_pop) void'(m_q.pop_front());
        m_note = 1'b0;
        if (pend != 0 && !full) begin
            found = 0;
            for (int i = 0; i < NK; i++) begin
                if (!found && pend[i]) begin
                    found    = 1;
                    m_num[i] = m_keys[i];
                    m_q.push_back(i * 2 + int'(m_keys[i]));
                end
            end
            m_note = 1'b1;
        end
        m_keys = k;
    endtask

    // One clock: apply inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input logic [NK-1:0] k, input logic rdy, input logic rst);
        keys_in  = k;
        ev_ready = rdy;
        reset    = rst;
        @(negedge clock);
        compare_model();
        if (ev_valid && ev_ready && !reset) drained.push_back(int'(ev_key));
        model_step(k, rdy, rst);
        @(posedge clock);
        #1;
    endtask

    logic [NK-1:0] rk;
    logic          rr;
    logic          rs;
    bit            order_ok;
    bit            saw10;

    initial begin
        keys_in  = '0;
        ev_ready = 1'b1;
        reset    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_step('0, 1'b1, 1'b1);

        // Ordered press of keys 0 and 2.
        cycle('0, 1'b1, 1'b1);
        check("reset_key_num", 32'(key_num), 32'h0);
        check("reset_ev_valid", 32'(ev_valid), 32'h0);
        cycle(17'h00005, 1'b1, 1'b0);
        cycle(17'h00005, 1'b1, 1'b0);
        check("press0_key_num", 32'(key_num), 32'h1);
        check("press0_note", 32'(note_ready), 32'h1);
        check("press0_ev", {ev_key, ev_press}, {5'd0, 1'b1});
        cycle(17'h00005, 1'b1, 1'b0);
        check("press2_key_num", 32'(key_num), 32'h5);
        check("press2_ev", {ev_key, ev_press}, {5'd2, 1'b1});
        cycle(17'h00005, 1'b1, 1'b0);
        check("press_note_low", 32'(note_ready), 32'h0);

        // Top key press then release.
        cycle(17'h10000, 1'b1, 1'b1);
        repeat (6) cycle(17'h10000, 1'b1, 1'b0);
        check("top_key_num", 32'(key_num), 32'h10000);
        cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        check("release_ev", {ev_key, ev_press}, {5'd16, 1'b0});
        check("release_key_num", 32'(key_num), 32'h0);
        repeat (3) cycle('0, 1'b1, 1'b0);

        // Fill FIFO with consumer stalled; key 10 glitches while full.
        cycle('0, 1'b1, 1'b1);
        repeat (12) cycle(17'h1FBFF, 1'b0, 1'b0);
        check("full_key_num", 32'(key_num), 32'h000FF);
        check("full_count", 32'(ev_count), 32'd8);
        check("full_overflow", 32'(overflow), 32'h1);
        repeat (2) cycle(17'h1FFFF, 1'b0, 1'b0);
        repeat (3) cycle(17'h1FBFF, 1'b0, 1'b0);
        drained.delete();
        repeat (30) cycle(17'h1FBFF, 1'b1, 1'b0);
        check("drain_len", 32'(drained.size()), 32'd16);
        order_ok = 1;
        saw10    = 0;
        foreach (drained[i]) begin
            if (i > 0 && drained[i] <= drained[i-1]) order_ok = 0;
            if (drained[i] == 10) saw10 = 1;
        end
        check("drain_order", 32'(order_ok), 32'h1);
        check("glitch_no_ev", 32'(saw10), 32'h0);
        check("drain_key_num", 32'(key_num), 32'h1FBFF);

        // Reset mid-stream with keys 3 and 4 held.
        cycle('0, 1'b1, 1'b1);
        repeat (7) cycle(17'h0001F, 1'b0, 1'b0);
        check("queued5", 32'(ev_count), 32'd5);
        cycle(17'h00018, 1'b0, 1'b1);
        check("rst_key_num", 32'(key_num), 32'h0);
        check("rst_count", 32'(ev_count), 32'h0);
        check("rst_ev_key", 32'(ev_key), 32'h0);
        cycle(17'h00018, 1'b1, 1'b0);
        cycle(17'h00018, 1'b1, 1'b0);
        check("post_rst_ev3", {ev_key, ev_press}, {5'd3, 1'b1});
        cycle(17'h00018, 1'b1, 1'b0);
        check("post_rst_ev4", {ev_key, ev_press}, {5'd4, 1'b1});
        check("post_rst_ovf", 32'(overflow), 32'h0);
        repeat (3) cycle(17'h00018, 1'b1, 1'b0);

        // Random traffic: sparse key flips, bursty consumer, rare resets.
        rk = 17'h00018;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rk[$urandom_range(0, NK - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) rk ^= NK'($urandom);
            rr = ($urandom_range(0, 9) < ((n / 300) % 2 == 0 ? 8 : 2));
            rs = ($urandom_range(0, 399) == 0);
            cycle(rk, rr, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
